// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: funct3 codes, FSM encoding, legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B   = 3'b000;
  localparam logic [2:0] F3_H   = 3'b001;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BU  = 3'b100;
  localparam logic [2:0] F3_HU  = 3'b101;
  localparam logic [2:0] F3_NOP = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    LOCK1 = 2'd3
  } arb_state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter; master = requester side, slave = arbiter side.
interface dmem_port_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, funct3, addr, wdata, lock,
                  input  gnt, rvalid, rdata, err);
  modport slave  (input  req, we, funct3, addr, wdata, lock,
                  output gnt, rvalid, rdata, err);
endinterface

// File: rtl/dmem_rd_return.sv
// Read-return pipe: one-deep register of (pending, owner), steers mem_rdata to the owner next cycle.
// No stall: a new load grant simply overwrites the entry consumed this cycle.
module dmem_rd_return #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              owner,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic rd_pending;
  logic rd_owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pending <= issue;
      if (issue) rd_owner <= owner;
    end
  end

  assign rvalid0 = rd_pending && !rd_owner;
  assign rvalid1 = rd_pending &&  rd_owner;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the single-port data memory, with a bounded port-1 burst lock.
// Grant is combinational in the request cycle; load data returns one cycle later; losers simply hold req.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 8,
  parameter int LOCK_CW  = 4
) (
  input  logic              clk,
  input  logic              rst,
  dmem_port_if.slave        p0,
  dmem_port_if.slave        p1,
  output logic              mem_we,
  output logic [2:0]        mem_funct3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t         state, state_n;
  logic               rr_ptr, rr_n;
  logic [LOCK_CW-1:0] lock_cnt, cnt_n;
  logic               gnt0, gnt1;
  logic               lock_full;
  logic               sel_we, legal, any_gnt;
  logic [2:0]         sel_f3;
  logic               rv0, rv1;
  logic [DATA_W-1:0]  rd0, rd1;

  assign lock_full = (lock_cnt == LOCK_CW'(MAX_LOCK));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      lock_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_n;
      lock_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    rr_n    = rr_ptr;
    cnt_n   = lock_cnt;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    if (state == LOCK1 && p1.req && !(lock_full && p0.req)) begin
      gnt1 = 1'b1;
      if (p1.lock) begin
        state_n = LOCK1;
        if (p0.req) cnt_n = lock_cnt + LOCK_CW'(1);
      end else begin
        state_n = OWN1;
        cnt_n   = '0;
        if (p0.req) rr_n = 1'b0;
      end
    end else if (state == LOCK1 && lock_full && p0.req) begin
      // Burst budget spent: port 0 gets one beat and port 1 is favoured afterwards.
      gnt0    = 1'b1;
      state_n = OWN0;
      rr_n    = 1'b1;
      cnt_n   = '0;
    end else begin
      cnt_n = '0;
      if (p0.req && p1.req) begin
        gnt0 = !rr_ptr;
        gnt1 = rr_ptr;
        rr_n = !rr_ptr;
      end else begin
        gnt0 = p0.req;
        gnt1 = p1.req;
      end
      if (gnt0) begin
        state_n = OWN0;
      end else if (gnt1) begin
        if (p1.lock) begin
          state_n = LOCK1;
          cnt_n   = LOCK_CW'(1);
        end else begin
          state_n = OWN1;
        end
      end else begin
        state_n = IDLE;
      end
    end
  end

  assign sel_we   = gnt1 ? p1.we     : p0.we;
  assign sel_f3   = gnt1 ? p1.funct3 : p0.funct3;
  assign any_gnt  = gnt0 || gnt1;
  assign legal    = f3_legal(sel_we, sel_f3);

  // Illegal or absent commands become a no-op read so the memory read register holds.
  assign mem_we     = any_gnt && legal && sel_we;
  assign mem_funct3 = (any_gnt && legal) ? sel_f3 : F3_NOP;
  assign mem_addr   = gnt1 ? p1.addr  : p0.addr;
  assign mem_wdata  = gnt1 ? p1.wdata : p0.wdata;

  assign p0.gnt = gnt0;
  assign p1.gnt = gnt1;
  assign p0.err = gnt0 && !legal;
  assign p1.err = gnt1 && !legal;

  dmem_rd_return #(.DATA_W(DATA_W)) u_rd_return (
    .clk       (clk),
    .rst       (rst),
    .issue     (any_gnt && legal && !sel_we),
    .owner     (gnt1),
    .mem_rdata (mem_rdata),
    .rvalid0   (rv0),
    .rvalid1   (rv1),
    .rdata0    (rd0),
    .rdata1    (rd1)
  );

  assign p0.rvalid = rv0;
  assign p1.rvalid = rv1;
  assign p0.rdata  = rd0;
  assign p1.rdata  = rd1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 1024x32 sub-word memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_port_if #(.ADDR_W(10), .DATA_W(32)) p0_if ();
  dmem_port_if #(.ADDR_W(10), .DATA_W(32)) p1_if ();

  logic        mem_we;
  logic [2:0]  mem_funct3;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_LOCK(8), .LOCK_CW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0         (p0_if),
    .p1         (p1_if),
    .mem_we     (mem_we),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_we) begin
      case (mem_funct3)
        F3_B:    mem[mem_addr][7:0]  <= mem_wdata[7:0];
        F3_H:    mem[mem_addr][15:0] <= mem_wdata[15:0];
        default: mem[mem_addr]       <= mem_wdata;
      endcase
    end else begin
      case (mem_funct3)
        F3_B:    mem_rdata <= {{24{mem[mem_addr][7]}},  mem[mem_addr][7:0]};
        F3_H:    mem_rdata <= {{16{mem[mem_addr][15]}}, mem[mem_addr][15:0]};
        F3_BU:   mem_rdata <= {24'h0, mem[mem_addr][7:0]};
        F3_HU:   mem_rdata <= {16'h0, mem[mem_addr][15:0]};
        F3_NOP:  mem_rdata <= mem_rdata;
        default: mem_rdata <= mem[mem_addr];
      endcase
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        port;
    logic        err;
    logic        we;
    logic [2:0]  f3;
    logic [9:0]  addr;
    logic [31:0] wdata;
  } gexp_t;

  typedef struct packed {
    logic        port;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t mg;
  rexp_t mr;

  task automatic exp_g(input logic port, input logic err, input logic we,
                       input logic [2:0] f3, input logic [9:0] addr, input logic [31:0] wd);
    gexp_t g;
    g.port  = port;
    g.err   = err;
    g.we    = err ? 1'b0 : we;
    g.f3    = err ? 3'b011 : f3;
    g.addr  = addr;
    g.wdata = wd;
    gq.push_back(g);
  endtask

  task automatic exp_r(input logic port, input logic [31:0] data);
    rexp_t r;
    r.port = port;
    r.data = data;
    rq.push_back(r);
  endtask

  // Monitor: every grant and every read return is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (p0_if.gnt || p1_if.gnt) begin
        if (gq.size() == 0) begin
          check("unexpected_gnt", 32'({p1_if.gnt, p0_if.gnt}), 32'd0);
        end else begin
          mg = gq.pop_front();
          check("gnt_port", 32'({p1_if.gnt, p0_if.gnt}), mg.port ? 32'd2 : 32'd1);
          check("gnt_err", 32'({p1_if.err, p0_if.err}), mg.err ? (mg.port ? 32'd2 : 32'd1) : 32'd0);
          check("mem_we", 32'(mem_we), 32'(mg.we));
          check("mem_funct3", 32'(mem_funct3), 32'(mg.f3));
          if (!mg.err) check("mem_addr", 32'(mem_addr), 32'(mg.addr));
          if (!mg.err && mg.we) check("mem_wdata", mem_wdata, mg.wdata);
        end
      end else begin
        check("idle_cmd", 32'({mem_we, mem_funct3, p1_if.err, p0_if.err}), 32'({1'b0, 3'b011, 2'b00}));
      end
      if (p0_if.rvalid || p1_if.rvalid) begin
        if (rq.size() == 0) begin
          check("unexpected_rvalid", 32'({p1_if.rvalid, p0_if.rvalid}), 32'd0);
        end else begin
          mr = rq.pop_front();
          check("rvalid_port", 32'({p1_if.rvalid, p0_if.rvalid}), mr.port ? 32'd2 : 32'd1);
          check("rdata_owner", mr.port ? p1_if.rdata : p0_if.rdata, mr.data);
          check("rdata_other", mr.port ? p0_if.rdata : p1_if.rdata, 32'd0);
        end
      end
    end
  end

  task automatic set_port(input logic port, input logic req, input logic we, input logic [2:0] f3,
                          input logic [9:0] addr, input logic [31:0] wd, input logic lock);
    if (port) begin
      p1_if.req = req; p1_if.we = we; p1_if.funct3 = f3;
      p1_if.addr = addr; p1_if.wdata = wd; p1_if.lock = lock;
    end else begin
      p0_if.req = req; p0_if.we = we; p0_if.funct3 = f3;
      p0_if.addr = addr; p0_if.wdata = wd; p0_if.lock = lock;
    end
  endtask

  task automatic single(input logic port, input logic we, input logic [2:0] f3,
                        input logic [9:0] addr, input logic [31:0] wd);
    logic got;
    got = 1'b0;
    set_port(port, 1'b1, we, f3, addr, wd, 1'b0);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = port ? p1_if.gnt : p0_if.gnt;
    end
    if (!got) check("single_gnt_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    set_port(port, 1'b0, 1'b0, 3'b000, 10'd0, 32'd0, 1'b0);
  endtask

  task automatic wait_grants(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n * 4 + 20 && seen < n; i++) begin
      @(negedge clk);
      if (p0_if.gnt || p1_if.gnt) seen++;
    end
    if (seen < n) check("grant_count_timeout", 32'(seen), 32'(n));
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 3'b000, 10'd0, 32'd0, 1'b0);
    set_port(1'b1, 1'b0, 1'b0, 3'b000, 10'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt",    32'({p1_if.gnt, p0_if.gnt}), 32'd0);
    check("rst_rvalid", 32'({p1_if.rvalid, p0_if.rvalid}), 32'd0);
    check("rst_err",    32'({p1_if.err, p0_if.err}), 32'd0);
    check("rst_mem_cmd", 32'({mem_we, mem_funct3}), 32'({1'b0, 3'b011}));
    @(posedge clk); #1 rst = 1'b0;

    // Port 0 store then load of the same word.
    exp_g(0, 0, 1, F3_W, 10'd5, 32'hDEADBEEF);
    single(0, 1, F3_W, 10'd5, 32'hDEADBEEF);
    exp_g(0, 0, 0, F3_W, 10'd5, 32'h0); exp_r(0, 32'hDEADBEEF);
    single(0, 0, F3_W, 10'd5, 32'h0);

    // Port 1 byte store and sign/zero-extended sub-word loads.
    exp_g(1, 0, 1, F3_B, 10'd7, 32'h000000AB);
    single(1, 1, F3_B, 10'd7, 32'h000000AB);
    exp_g(1, 0, 0, F3_B, 10'd7, 32'h0);  exp_r(1, 32'hFFFFFFAB);
    single(1, 0, F3_B, 10'd7, 32'h0);
    exp_g(1, 0, 0, F3_BU, 10'd7, 32'h0); exp_r(1, 32'h000000AB);
    single(1, 0, F3_BU, 10'd7, 32'h0);
    exp_g(0, 0, 0, F3_H, 10'd5, 32'h0);  exp_r(0, 32'hFFFFBEEF);
    single(0, 0, F3_H, 10'd5, 32'h0);
    exp_g(0, 0, 0, F3_HU, 10'd5, 32'h0); exp_r(0, 32'h0000BEEF);
    single(0, 0, F3_HU, 10'd5, 32'h0);
    exp_g(1, 0, 1, F3_W, 10'd9, 32'h12345678);
    single(1, 1, F3_W, 10'd9, 32'h12345678);

    // Contention straight after reset alternates p0, p1, p0, p1.
    reset_pulse();
    for (int i = 0; i < 2; i++) begin
      exp_g(0, 0, 0, F3_W, 10'd5, 32'h0); exp_r(0, 32'hDEADBEEF);
      exp_g(1, 0, 0, F3_W, 10'd9, 32'h0); exp_r(1, 32'h12345678);
    end
    set_port(0, 1, 0, F3_W, 10'd5, 32'h0, 0);
    set_port(1, 1, 0, F3_W, 10'd9, 32'h0, 0);
    wait_grants(4);
    set_port(0, 0, 0, 3'b000, 10'd0, 32'd0, 0);
    set_port(1, 0, 0, 3'b000, 10'd0, 32'd0, 0);

    // Port-1 locked burst against a waiting port 0: 8 p1, 1 p0, 8 p1, 1 p0.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) exp_g(1, 0, 1, F3_W, 10'd20, 32'h00001111);
      exp_g(0, 0, 0, F3_W, 10'd5, 32'h0); exp_r(0, 32'hDEADBEEF);
    end
    set_port(1, 1, 1, F3_W, 10'd20, 32'h00001111, 1);
    wait_grants(1);
    set_port(0, 1, 0, F3_W, 10'd5, 32'h0, 0);
    wait_grants(17);
    set_port(0, 0, 0, 3'b000, 10'd0, 32'd0, 0);
    set_port(1, 0, 0, 3'b000, 10'd0, 32'd0, 0);

    // Illegal funct3: grant with err, no-op command, memory untouched.
    exp_g(0, 1, 0, 3'b011, 10'd5, 32'h0);
    single(0, 0, 3'b011, 10'd5, 32'h0);
    exp_g(0, 1, 1, F3_BU, 10'd5, 32'h0);
    single(0, 1, F3_BU, 10'd5, 32'h0);
    exp_g(1, 1, 0, 3'b110, 10'd9, 32'h0);
    single(1, 0, 3'b110, 10'd9, 32'h0);
    exp_g(0, 0, 0, F3_W, 10'd5, 32'h0); exp_r(0, 32'hDEADBEEF);
    single(0, 0, F3_W, 10'd5, 32'h0);
    exp_g(1, 0, 0, F3_W, 10'd20, 32'h0); exp_r(1, 32'h00001111);
    single(1, 0, F3_W, 10'd20, 32'h0);

    // Reset in the cycle after a load grant drops the return.
    exp_g(0, 0, 0, F3_W, 10'd5, 32'h0);
    single(0, 0, F3_W, 10'd5, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_rvalid", 32'({p1_if.rvalid, p0_if.rvalid}), 32'd0);
    check("rstmid_rdata",  p0_if.rdata | p1_if.rdata, 32'd0);
    check("rstmid_gnt",    32'({p1_if.gnt, p0_if.gnt, p1_if.err, p0_if.err}), 32'd0);
    check("rstmid_mem_cmd", 32'({mem_we, mem_funct3}), 32'({1'b0, 3'b011}));
    @(posedge clk); #1 rst = 1'b0;
    exp_g(0, 0, 0, F3_W, 10'd5, 32'h0); exp_r(0, 32'hDEADBEEF);
    exp_g(1, 0, 0, F3_W, 10'd9, 32'h0); exp_r(1, 32'h12345678);
    set_port(0, 1, 0, F3_W, 10'd5, 32'h0, 0);
    set_port(1, 1, 0, F3_W, 10'd9, 32'h0, 0);
    wait_grants(2);
    set_port(0, 0, 0, 3'b000, 10'd0, 32'd0, 0);
    set_port(1, 0, 0, 3'b000, 10'd0, 32'd0, 0);

    repeat (3) @(negedge clk);
    check("gnt_queue_drained", 32'(gq.size()), 32'd0);
    check("rd_queue_drained",  32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
